ifu_inst_buf: RTL and testbench
===============================

// Module: ifu_inst_buf
// PURPOSE
//  Instruction buffer between fetch and decode. Holds fetched instruction words with address and
//  branch-prediction flag. Presents the oldest entry first-word-fall-through to the decoder, which
//  then feeds idu_id_pipe. Absorbs decode-side stalls without back-pressuring fetch every cycle.
//  Drops all contents on a control-unit flush.
// PARAMETERS
//  DEPTH   4   entry count; power of two, >= 2
//  CNT_W   $clog2(DEPTH)+1   occupancy counter width (derived, not overridden)
// PORTS
//  clk               in   1                  core clock
//  rst_n             in   1                  asynchronous active-low reset
//  inst_valid_i      in   1                  fetch presents a valid instruction
//  inst_i            in   `INST_DATA_WIDTH   fetched instruction word
//  inst_addr_i       in   `INST_ADDR_WIDTH   fetched instruction address
//  is_pred_branch_i  in   1                  fetch predicted this instruction as taken branch
//  inst_ready_o      out  1                  buffer accepts a push this cycle
//  stall_flag_i      in   `CU_BUS_WIDTH      control bus; uses [`CU_FLUSH] and [`CU_STALL]
//  inst_valid_o      out  1                  head entry valid toward decode
//  inst_o            out  `INST_DATA_WIDTH   head instruction word
//  inst_addr_o       out  `INST_ADDR_WIDTH   head instruction address
//  is_pred_branch_o  out  1                  head prediction flag
//  count_o           out  CNT_W              current occupancy, 0..DEPTH
// BEHAVIOUR
//  Clock/reset: single clk; rst_n asynchronous active-low. Reset clears rd_ptr, wr_ptr and count to 0.
//  Reset values: inst_valid_o=0, inst_o=`INST_NOP (32'h0000_0013), inst_addr_o=`ZeroWord,
//   is_pred_branch_o=0, count_o=0, inst_ready_o=1. Entry storage contents are don't-care after reset.
//  flush = stall_flag_i[`CU_FLUSH]; stall = stall_flag_i[`CU_STALL].
//  inst_ready_o = (count != DEPTH). This is registered-state only, with no combinational path from
//   inst_valid_i or stall_flag_i.
//  push = inst_valid_i & inst_ready_o & ~flush. pop = inst_valid_o & ~stall & ~flush.
//  push writes entry[wr_ptr] and advances wr_ptr by 1 modulo DEPTH.
//   pop advances rd_ptr by 1 modulo DEPTH. Both use natural pointer wrap.
//  Count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  Push and pop in the same cycle are legal at any non-full occupancy.
//   When full, push is blocked even if a pop occurs that cycle; ready is not recomputed combinationally.
//  Empty (count==0): inst_valid_o=0, inst_o=`INST_NOP, inst_addr_o=`ZeroWord, is_pred_branch_o=0.
//   There is no bypass: an instruction pushed into an empty buffer appears at the outputs on the next cycle.
//  Non-empty: outputs show entry[rd_ptr] combinationally from storage. Latency push->visible is 1 cycle.
//  Flush has priority over everything. In the flush cycle, a same-cycle push is discarded, no pop occurs,
//   and on the next edge rd_ptr=wr_ptr=count=0. Outputs then read as empty.
//   Flush together with stall behaves as flush.
//  Stall without flush: head entry and outputs hold steady. Push continues while not full.
//  Asserting rst_n low mid-operation clears state immediately; outputs go to reset values asynchronously.
//  inst_valid_i while inst_ready_o=0 is ignored. Fetch must hold or replay the word; nothing is dropped silently.
//  Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when the pointers are equal
//   and the buffer is full.
// STRUCTURE
//  defines.svh supplies `CU_FLUSH, `CU_STALL, `CU_BUS_WIDTH, `INST_DATA_WIDTH,
//   `INST_ADDR_WIDTH, `ZeroWord and `INST_NOP. Add `INST_NOP there if it is absent.
//  Entry format {pred, addr, inst} as a packed width macro `IBUF_ENTRY_WIDTH in defines.svh.
//  Pointers and counter use gnrl_dfflr with enables.
//  One sub-module: ifu_inst_buf_ram: DEPTH x `IBUF_ENTRY_WIDTH register array.
//   Ports: write enable/address/data and asynchronous read address/data. No reset on the array.
// TESTING
//  1 Reset: hold rst_n=0 with random inputs -> inst_valid_o=0, inst_o=32'h13, count_o=0, inst_ready_o=1.
//  2 Fill: push A0..A3 (addr 0x80000000+4n) under stall=1 -> count_o=4, ready=0.
//    A 5th push is ignored. Release stall -> A0..A3 pop in order over 4 cycles.
//  3 Streaming: push and pop every cycle across 10 instructions -> count_o stays at 1 and order is preserved.
//    Pointers wrap past DEPTH with no loss or duplication.
//  4 Full with pop: at count=4, stall=0 and inst_valid_i=1 -> pop occurs, push is rejected, count_o=3.
//    Next cycle ready=1.
//  5 Flush: count=3 with flush=1, stall=1 and push of B -> next cycle count_o=0, inst_valid_o=0.
//    B never appears at the outputs.
//  6 Pred flag: push with is_pred_branch_i=1 at addr 0x80000010 -> flag emerges with that entry only.
//    Neighbouring entries show 0.

Source files
------------

// File: rtl/ifu_inst_buf_pkg.sv
// Entry layout and idle-output value for the fetch->decode instruction buffer.
`include "defines.svh"

package ifu_inst_buf_pkg;

    typedef struct packed {
        logic                        pred;
        logic [`INST_ADDR_WIDTH-1:0] addr;
        logic [`INST_DATA_WIDTH-1:0] inst;
    } ibuf_entry_t;

    // What decode sees while the buffer is empty.
    localparam ibuf_entry_t IDLE_ENTRY = '{pred: 1'b0, addr: `ZeroWord, inst: `INST_NOP};

endpackage

// File: rtl/defines.svh
// Shared core-wide widths, control-bus bit positions and reset/idle words.
`ifndef IFU_DEFINES_SVH
`define IFU_DEFINES_SVH

`define CU_BUS_WIDTH     2
`define CU_STALL         0
`define CU_FLUSH         1

`define INST_DATA_WIDTH  32
`define INST_ADDR_WIDTH  32
`define ZeroWord         32'h0000_0000

`ifndef INST_NOP
`define INST_NOP         32'h0000_0013
`endif

// Buffer entry packs {pred, addr, inst}.
`define IBUF_ENTRY_WIDTH (1 + `INST_ADDR_WIDTH + `INST_DATA_WIDTH)

`endif

// File: rtl/gnrl_dfflr.sv
// Generic D flip-flop with load enable and asynchronous active-low reset to zero.
module gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/ifu_inst_buf_ram.sv
// DEPTH x entry register array: one synchronous write port, one asynchronous read port.
`include "defines.svh"

module ifu_inst_buf_ram #(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic [`IBUF_ENTRY_WIDTH-1:0] wdata,
    input  logic [AW-1:0]                raddr,
    output logic [`IBUF_ENTRY_WIDTH-1:0] rdata
);

    // Storage is never reset; the occupancy count gates what is visible.
    logic [`IBUF_ENTRY_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ifu_inst_buf.sv
// Fetch->decode instruction buffer: FWFT FIFO of {pred, addr, inst} with stall hold and flush clear.
`include "defines.svh"

module ifu_inst_buf
    import ifu_inst_buf_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        inst_valid_i,
    input  logic [`INST_DATA_WIDTH-1:0] inst_i,
    input  logic [`INST_ADDR_WIDTH-1:0] inst_addr_i,
    input  logic                        is_pred_branch_i,
    output logic                        inst_ready_o,
    input  logic [`CU_BUS_WIDTH-1:0]    stall_flag_i,
    output logic                        inst_valid_o,
    output logic [`INST_DATA_WIDTH-1:0] inst_o,
    output logic [`INST_ADDR_WIDTH-1:0] inst_addr_o,
    output logic                        is_pred_branch_o,
    output logic [CNT_W-1:0]            count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             flush, stall, full, empty, push, pop;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             rd_ptr_en, wr_ptr_en, count_en;
    ibuf_entry_t      wr_entry, rd_entry, head;

    assign flush = stall_flag_i[`CU_FLUSH];
    assign stall = stall_flag_i[`CU_STALL];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Ready depends on registered occupancy only, so a full buffer refuses
    // a push even in a cycle where it also pops.
    assign inst_ready_o = ~full;
    assign push         = inst_valid_i & ~full & ~flush;
    assign pop          = ~empty & ~stall & ~flush;

    assign wr_ptr_en  = push | flush;
    assign wr_ptr_nxt = flush ? '0 : wr_ptr + PTR_W'(1);
    assign rd_ptr_en  = pop | flush;
    assign rd_ptr_nxt = flush ? '0 : rd_ptr + PTR_W'(1);

    always_comb begin
        count_en  = flush | (push ^ pop);
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    gnrl_dfflr #(.DW(PTR_W)) u_wr_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .lden (wr_ptr_en),
        .dnxt (wr_ptr_nxt),
        .qout (wr_ptr)
    );

    gnrl_dfflr #(.DW(PTR_W)) u_rd_ptr (
        .clk  (clk),
        .rst_n(rst_n),
        .lden (rd_ptr_en),
        .dnxt (rd_ptr_nxt),
        .qout (rd_ptr)
    );

    gnrl_dfflr #(.DW(CNT_W)) u_count (
        .clk  (clk),
        .rst_n(rst_n),
        .lden (count_en),
        .dnxt (count_nxt),
        .qout (count)
    );

    assign wr_entry = '{pred: is_pred_branch_i, addr: inst_addr_i, inst: inst_i};

    ifu_inst_buf_ram #(.DEPTH(DEPTH)) u_ram (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(wr_entry),
        .raddr(rd_ptr),
        .rdata(rd_entry)
    );

    // Empty masks stale storage; since count resets asynchronously the
    // outputs fall to idle values the moment rst_n drops.
    always_comb begin
        head = rd_entry;
        if (empty) begin
            head = IDLE_ENTRY;
        end
    end

    assign inst_valid_o     = ~empty;
    assign inst_o           = head.inst;
    assign inst_addr_o      = head.addr;
    assign is_pred_branch_o = head.pred;
    assign count_o          = count;

endmodule

// File: tb/tb_ifu_inst_buf.sv
// Randomized and directed bench for ifu_inst_buf against a queue-based reference model.
module tb_ifu_inst_buf;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic        is_pred_branch_i = 1'b0;
    logic [1:0]  stall_flag_i = '0;   // {flush, stall}
    logic        inst_ready_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        is_pred_branch_o;
    logic [2:0]  count_o;

    always #5 clk = ~clk;

    ifu_inst_buf #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_valid_i    (inst_valid_i),
        .inst_i          (inst_i),
        .inst_addr_i     (inst_addr_i),
        .is_pred_branch_i(is_pred_branch_i),
        .inst_ready_o    (inst_ready_o),
        .stall_flag_i    (stall_flag_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_addr_o     (inst_addr_o),
        .is_pred_branch_o(is_pred_branch_o),
        .count_o         (count_o)
    );

    typedef struct packed {
        logic        pred;
        logic [31:0] addr;
        logic [31:0] inst;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    logic [69:0] dut_out;
    assign dut_out = {inst_valid_o, is_pred_branch_o, inst_addr_o, inst_o, count_o, inst_ready_o};

    // Expected {valid, pred, addr, inst, count, ready} from the model queue.
    function automatic logic [69:0] model_out();
        if (q.size() == 0) return {1'b0, 1'b0, 32'h0, 32'h13, 3'd0, 1'b1};
        return {1'b1, q[0].pred, q[0].addr, q[0].inst, 3'(q.size()), q.size() != DEPTH};
    endfunction

    // Drive one cycle and advance the model by the FIFO rules; returns #1 after the edge.
    task automatic tick(input logic vi, input logic [31:0] d, input logic [31:0] a,
                        input logic p, input logic st, input logic fl);
        bit ready, push, pop;
        inst_valid_i = vi; inst_i = d; inst_addr_i = a; is_pred_branch_i = p;
        stall_flag_i = {fl, st};
        ready = (q.size() != DEPTH);
        push  = vi && ready && !fl;
        pop   = (q.size() != 0) && !st && !fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back('{p, a, d});
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            inst_valid_i = 1'($urandom); inst_i = $urandom; inst_addr_i = $urandom;
            is_pred_branch_i = 1'($urandom); stall_flag_i = 2'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (inst_valid_o !== 1'b0 || inst_o !== 32'h13 || count_o !== 3'd0 || inst_ready_o !== 1'b1
                || inst_addr_o !== 32'h0 || is_pred_branch_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset: got valid=%b inst=%h addr=%h pred=%b count=%0d ready=%b, want 0 00000013 0 0 0 1",
                         inst_valid_o, inst_o, inst_addr_o, is_pred_branch_o, count_o, inst_ready_o);
            end
        end
        inst_valid_i = 1'b0; stall_flag_i = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", dut_out, model_out());
        end
    endtask

    task automatic test_fill();
        logic [31:0] a_inst [4];
        for (int i = 0; i < 4; i++) a_inst[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, a_inst[i], 32'h8000_0000 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (count_o !== 3'(i + 1) || inst_o !== a_inst[0]) begin
                n_fail++;
                $display("FAIL fill_count: got count=%0d head=%h want count=%0d head=%h", count_o, inst_o, i + 1, a_inst[0]);
            end
        end
        n_checks++;
        if (inst_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_ready: got %b want 0", inst_ready_o);
        end
        tick(1'b1, 32'hdead_beef, 32'h8000_0100, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (count_o !== 3'd4 || inst_o !== a_inst[0] || dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL fill_fifth_push: got count=%0d head=%h want 4 %h", count_o, inst_o, a_inst[0]);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (inst_valid_o !== 1'b1 || inst_o !== a_inst[i] || inst_addr_o !== 32'h8000_0000 + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL fill_drain_%0d: got v=%b inst=%h addr=%h want 1 %h %h", i, inst_valid_o, inst_o,
                         inst_addr_o, a_inst[i], 32'h8000_0000 + 32'(4 * i));
            end
            tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        end
        n_checks++;
        if (inst_valid_o !== 1'b0 || count_o !== 3'd0 || inst_o !== 32'h13) begin
            n_fail++;
            $display("FAIL fill_empty: got v=%b count=%0d inst=%h want 0 0 00000013", inst_valid_o, count_o, inst_o);
        end
    endtask

    task automatic test_stream();
        logic [31:0] s [10];
        for (int i = 0; i < 10; i++) s[i] = $urandom;
        tick(1'b1, s[0], 32'h9000_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            n_checks++;
            if (count_o !== 3'd1 || inst_o !== s[i - 1] || inst_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_%0d: got count=%0d inst=%h want 1 %h", i, count_o, inst_o, s[i - 1]);
            end
            tick(1'b1, s[i], 32'h9000_0000 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
        end
        n_checks++;
        if (count_o !== 3'd1 || inst_o !== s[9]) begin
            n_fail++;
            $display("FAIL stream_last: got count=%0d inst=%h want 1 %h", count_o, inst_o, s[9]);
        end
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: got count=%0d v=%b want 0 0", count_o, inst_valid_o);
        end
    endtask

    task automatic test_full_pop_flush();
        logic [31:0] f [4];
        logic [31:0] b;
        for (int i = 0; i < 4; i++) begin
            f[i] = $urandom;
            tick(1'b1, f[i], 32'hA000_0000 + 32'(4 * i), 1'b0, 1'b1, 1'b0);
        end
        tick(1'b1, 32'h0bad_c0de, 32'hA000_0100, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (count_o !== 3'd3 || inst_ready_o !== 1'b1 || inst_o !== f[1]) begin
            n_fail++;
            $display("FAIL full_pop: got count=%0d ready=%b head=%h want 3 1 %h", count_o, inst_ready_o, inst_o, f[1]);
        end
        b = 32'h0000_b00b;
        tick(1'b1, b, 32'hB000_0000, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0 || inst_o !== 32'h13) begin
            n_fail++;
            $display("FAIL flush: got count=%0d v=%b inst=%h want 0 0 00000013", count_o, inst_valid_o, inst_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (inst_valid_o !== 1'b0 || inst_o === b) begin
                n_fail++;
                $display("FAIL flush_ghost_%0d: got v=%b inst=%h want 0 00000013", i, inst_valid_o, inst_o);
            end
        end
    endtask

    task automatic test_pred();
        logic [31:0] a [3];
        logic        want [3];
        a[0] = 32'h8000_000c; a[1] = 32'h8000_0010; a[2] = 32'h8000_0014;
        want[0] = 1'b0; want[1] = 1'b1; want[2] = 1'b0;
        for (int i = 0; i < 3; i++)
            tick(1'b1, $urandom, a[i], a[i] == 32'h8000_0010, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (is_pred_branch_o !== want[i] || inst_addr_o !== a[i]) begin
                n_fail++;
                $display("FAIL pred_%0d: got pred=%b addr=%h want %b %h", i, is_pred_branch_o, inst_addr_o, want[i], a[i]);
            end
            tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, $urandom, 32'hC000_0000, 1'b1, 1'b1, 1'b0);
        tick(1'b1, $urandom, 32'hC000_0004, 1'b0, 1'b1, 1'b0);
        inst_valid_i = 1'b0; stall_flag_i = 2'b01;
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        n_checks++;
        if (dut_out !== model_out()) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", dut_out, model_out());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stall_flag_i = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
            n_checks++;
            if (dut_out !== model_out()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h want %h", i, dut_out, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_full_pop_flush();
        test_pred();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
